// File: rtl/pplimit_mc_pkg.sv
// Shared constants and helpers for the multi-channel saturating limiter.
package pplimit_mc_pkg;

    // Width of every channel index bus (supports up to 16 channels).
    localparam int CHW = 4;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Largest symmetric magnitude of a wo-bit signed sample: 2^(wo-1)-1.
    function automatic longint unsigned full_scale(input int wo);
        return (longint'(1) << (wo - 1)) - 1;
    endfunction

    // Saturation value of a cw-bit counter: 2^cw-1.
    function automatic longint unsigned cnt_sat(input int cw);
        return (longint'(1) << cw) - 1;
    endfunction

endpackage

// File: rtl/pplimit_mc_cnt.sv
// Bank of NCH saturating clip counters with one increment port, one clear
// port and a registered read port. Addresses at or above NCH read as zero
// and are never cleared or incremented.
module pplimit_mc_cnt
    import pplimit_mc_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           inc_en,
    input  logic [CHW-1:0] inc_addr,
    input  logic           clr_en,
    input  logic [CHW-1:0] clr_addr,
    input  logic [CHW-1:0] rd_addr,
    output logic [CW-1:0]  rd_data
);

    localparam int            NSLOT   = 1 << CHW;
    localparam logic [CW-1:0] CNT_MAX = CW'(cnt_sat(CW));

    logic [CW-1:0] cnt_val [NSLOT];
    logic [CW-1:0] rd_data_reg;

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_cnt
            if (gi < NCH) begin : g_live
                logic [CW-1:0] c_reg;

                // Saturating counter; a clear in the same cycle as an increment wins.
                always_ff @(posedge clk) begin
                    if (srst) begin
                        c_reg <= '0;
                    end else if (clr_en && (clr_addr == CHW'(gi))) begin
                        c_reg <= '0;
                    end else if (inc_en && (inc_addr == CHW'(gi)) && (c_reg != CNT_MAX)) begin
                        c_reg <= c_reg + CW'(1);
                    end
                end

                assign cnt_val[gi] = c_reg;
            end else begin : g_none
                assign cnt_val[gi] = '0;
            end
        end
    endgenerate

    // Registered read: returns the count as it stood before this edge's update.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= cnt_val[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/pplimit_mc.sv
// Multi-channel time-interleaved saturating limiter.
// Samples arrive round-robin over NCH channels; each is clamped symmetrically
// to a per-channel limit and narrowed to WO bits with 2-cycle latency.
// Optional feature macro: PPLIMIT_MC_CLIPCNT_EN enables the per-channel clip
// counters (cnt_addr/cnt_clr/clip_cnt); otherwise clip_cnt is tied to zero.
module pplimit_mc
    import pplimit_mc_pkg::*;
#(
    parameter int WI  = 8,
    parameter int WO  = 7,
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [WI-1:0]  in,
    input  logic           strobe_in,
    input  logic           frame_in,
    input  logic           lim_we,
    input  logic [CHW-1:0] lim_addr,
    input  logic [WO-2:0]  lim_data,
    output logic [WO-1:0]  out,
    output logic           strobe_out,
    output logic [CHW-1:0] ch_out,
    output logic           clip_out,
    input  logic [CHW-1:0] cnt_addr,
    input  logic           cnt_clr,
    output logic [CW-1:0]  clip_cnt
);

    localparam int             NSLOT       = 1 << CHW;
    localparam logic [WO-2:0]  LIM_DEFAULT = (WO-1)'(full_scale(WO));
    localparam logic [CHW-1:0] LAST_CH     = CHW'(NCH - 1);

    // ---------------- channel sequencing ----------------
    logic [CHW-1:0] ch_reg;
    logic [CHW-1:0] cur_ch;
    logic [CHW-1:0] ch_next;

    // Channel of the incoming sample (frame forces 0) and the one after it.
    always_comb begin
        cur_ch  = frame_in ? '0 : ch_reg;
        ch_next = (cur_ch == LAST_CH) ? '0 : cur_ch + CHW'(1);
    end

    // Advance the round-robin index on every accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_reg <= '0;
        end else if (strobe_in) begin
            ch_reg <= ch_next;
        end
    end

    // ---------------- per-channel limit registers ----------------
    logic [WO-2:0] lim_val [NSLOT];

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_lim
            if (gi < NCH) begin : g_live
                logic [WO-2:0] l_reg;

                // Host-written limit; writes to addresses >= NCH match no register.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        l_reg <= LIM_DEFAULT;
                    end else if (lim_we && (lim_addr == CHW'(gi))) begin
                        l_reg <= lim_data;
                    end
                end

                assign lim_val[gi] = l_reg;
            end else begin : g_none
                assign lim_val[gi] = LIM_DEFAULT;
            end
        end
    endgenerate

    // ---------------- stage 1: capture sample, channel and limit ----------------
    logic                 s1_valid_reg;
    logic signed [WI-1:0] s1_in_reg;
    logic [CHW-1:0]       s1_ch_reg;
    logic [WO-2:0]        s1_lim_reg;

    // The limit is sampled here, so a same-cycle write is seen only by later samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_in_reg    <= '0;
            s1_ch_reg    <= '0;
            s1_lim_reg   <= '0;
        end else begin
            s1_valid_reg <= strobe_in;
            if (strobe_in) begin
                s1_in_reg  <= $signed(in);
                s1_ch_reg  <= cur_ch;
                s1_lim_reg <= lim_val[cur_ch];
            end
        end
    end

    // ---------------- stage 2: compare and clamp ----------------
    logic signed [WI-1:0] lim_pos;
    logic signed [WI-1:0] lim_neg;
    logic signed [WO-1:0] sat_next;
    logic                 clip_next;

    // Symmetric clamp to +/-L; in-range samples fit WO bits exactly.
    always_comb begin
        lim_pos   = $signed({{(WI-WO+1){1'b0}}, s1_lim_reg});
        lim_neg   = -lim_pos;
        sat_next  = s1_in_reg[WO-1:0];
        clip_next = 1'b0;
        if (s1_in_reg > lim_pos) begin
            sat_next  = $signed({1'b0, s1_lim_reg});
            clip_next = 1'b1;
        end else if (s1_in_reg < lim_neg) begin
            sat_next  = -$signed({1'b0, s1_lim_reg});
            clip_next = 1'b1;
        end
    end

    logic [WO-1:0]  out_reg;
    logic           strobe_out_reg;
    logic [CHW-1:0] ch_out_reg;
    logic           clip_out_reg;

    // Output register; data fields hold while no sample is delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg        <= '0;
            strobe_out_reg <= 1'b0;
            ch_out_reg     <= '0;
            clip_out_reg   <= 1'b0;
        end else begin
            strobe_out_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_reg      <= sat_next;
                ch_out_reg   <= s1_ch_reg;
                clip_out_reg <= clip_next;
            end
        end
    end

    assign out        = out_reg;
    assign strobe_out = strobe_out_reg;
    assign ch_out     = ch_out_reg;
    assign clip_out   = clip_out_reg;

    // ---------------- clip counters ----------------
`ifdef PPLIMIT_MC_CLIPCNT_EN
    pplimit_mc_cnt #(
        .NCH (NCH),
        .CW  (CW)
    ) u_cnt (
        .clk      (clk),
        .srst     (rst),
        .inc_en   (strobe_out_reg & clip_out_reg),
        .inc_addr (ch_out_reg),
        .clr_en   (cnt_clr),
        .clr_addr (cnt_addr),
        .rd_addr  (cnt_addr),
        .rd_data  (clip_cnt)
    );
`else
    logic unused_cnt;
    assign unused_cnt = &{1'b0, cnt_addr, cnt_clr};
    assign clip_cnt   = '0;
`endif

endmodule

// File: tb/tb_pplimit_mc.sv
// Self-checking bench for pplimit_mc: a behavioural model predicts every
// output each cycle, and directed scenarios pin the model with literal values.
// Works with or without PPLIMIT_MC_CLIPCNT_EN defined.
`timescale 1ns/1ps
module tb_pplimit_mc;

    localparam int WI  = 8;
    localparam int WO  = 7;
    localparam int NCH = 4;
    localparam int CW  = 4;
`ifdef PPLIMIT_MC_CLIPCNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic          clk;
    logic          rst;
    logic [WI-1:0] din;
    logic          strobe_in;
    logic          frame_in;
    logic          lim_we;
    logic [3:0]    lim_addr;
    logic [WO-2:0] lim_data;
    logic [WO-1:0] dout;
    logic          strobe_out;
    logic [3:0]    ch_out;
    logic          clip_out;
    logic [3:0]    cnt_addr;
    logic          cnt_clr;
    logic [CW-1:0] clip_cnt;

    pplimit_mc #(.WI(WI), .WO(WO), .NCH(NCH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (din),
        .strobe_in  (strobe_in),
        .frame_in   (frame_in),
        .lim_we     (lim_we),
        .lim_addr   (lim_addr),
        .lim_data   (lim_data),
        .out        (dout),
        .strobe_out (strobe_out),
        .ch_out     (ch_out),
        .clip_out   (clip_out),
        .cnt_addr   (cnt_addr),
        .cnt_clr    (cnt_clr),
        .clip_cnt   (clip_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_lim [NCH];
    int m_cnt [NCH];
    int m_ch;
    bit pend_v;
    int pend_val, pend_ch, pend_clip;
    int e_strobe, e_out, e_ch, e_clip, e_cnt;

    function automatic int limit_sample(input int x, input int lim, output int clipped);
        clipped = 1;
        if (x > lim)  return lim;
        if (x < -lim) return -lim;
        clipped = 0;
        return x;
    endfunction

    // Model update: evaluated on each rising edge with the inputs held at that edge.
    task automatic model_step();
        int c, rd, x;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_lim[i] = (1 << (WO - 1)) - 1;
                m_cnt[i] = 0;
            end
            m_ch = 0; pend_v = 0;
            e_strobe = 0; e_out = 0; e_ch = 0; e_clip = 0; e_cnt = 0;
        end else begin
            rd = (int'(cnt_addr) < NCH) ? m_cnt[int'(cnt_addr)] : 0;
            if (e_strobe != 0 && e_clip != 0 && m_cnt[e_ch] < (1 << CW) - 1)
                m_cnt[e_ch] = m_cnt[e_ch] + 1;
            if (cnt_clr && int'(cnt_addr) < NCH)
                m_cnt[int'(cnt_addr)] = 0;
            e_cnt = (CNT_ON != 0) ? rd : 0;
            e_strobe = pend_v ? 1 : 0;
            if (pend_v) begin
                e_out = pend_val; e_ch = pend_ch; e_clip = pend_clip;
            end
            if (strobe_in) begin
                c = frame_in ? 0 : m_ch;
                m_ch = (c + 1) % NCH;
                x = $signed(din);
                pend_val = limit_sample(x, m_lim[c], pend_clip);
                pend_ch = c;
                pend_v = 1'b1;
            end else begin
                pend_v = 1'b0;
            end
            if (lim_we && int'(lim_addr) < NCH)
                m_lim[int'(lim_addr)] = int'(lim_data);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process + output log ----------------
    int q_out[$];
    int q_ch[$];
    int q_clip[$];

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("strobe_out", int'(strobe_out), e_strobe);
            check("out", $signed(dout), e_out);
            check("ch_out", int'(ch_out), e_ch);
            check("clip_out", int'(clip_out), e_clip);
            check("clip_cnt", int'(clip_cnt), e_cnt);
            if (strobe_out) begin
                q_out.push_back($signed(dout));
                q_ch.push_back(int'(ch_out));
                q_clip.push_back(int'(clip_out));
                $display("out: ch=%0d val=%0d clip=%0d cnt=%0d", ch_out, $signed(dout), clip_out, clip_cnt);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input int v, input bit fr);
        strobe_in = 1'b1;
        frame_in  = fr;
        din       = WI'(v);
        tick();
        strobe_in = 1'b0;
        frame_in  = 1'b0;
    endtask

    task automatic clear_log();
        q_out.delete(); q_ch.delete(); q_clip.delete();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int exp1_v[5] = '{63, -63, -63, 63, -63};
        int exp1_c[5] = '{1, 1, 1, 0, 0};
        int exp2_v[4] = '{30, -20, 10, 20};
        int exp2_c[4] = '{0, 1, 0, 1};
        int exp3_ch[7] = '{0, 1, 2, 3, 0, 1, 0};
        int exp3_v[7]  = '{50, 50, 20, 50, 50, 50, 50};
        int k, other_clips;

        rst = 1'b1; din = '0; strobe_in = 1'b0; frame_in = 1'b0;
        lim_we = 1'b0; lim_addr = '0; lim_data = '0; cnt_addr = '0; cnt_clr = 1'b0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        check("rst_out", $signed(dout), 0);
        check("rst_strobe", int'(strobe_out), 0);
        check("rst_clip_cnt", int'(clip_cnt), 0);
        rst = 1'b0;
        tick();

        // Scenario 1: default full-scale limit on channel 0.
        clear_log();
        send(100, 1); send(-100, 1); send(-64, 1); send(63, 1); send(-63, 1);
        repeat (4) tick();
        check("s1_count", q_out.size(), 5);
        for (int i = 0; i < 5 && i < q_out.size(); i++) begin
            check("s1_val", q_out[i], exp1_v[i]);
            check("s1_clip", q_clip[i], exp1_c[i]);
            check("s1_ch", q_ch[i], 0);
        end

        // Scenario 2: L=20 on ch2, written coincident with a ch2 sample.
        clear_log();
        send(30, 1); send(30, 0);
        lim_we = 1'b1; lim_addr = 4'd2; lim_data = 6'd20;
        send(30, 0);
        lim_we = 1'b0;
        send(30, 0);
        foreach (exp2_v[r]) if (r > 0) begin
            send(r == 1 ? -30 : (r == 2 ? 10 : 30), 1);
            send(r == 1 ? -30 : (r == 2 ? 10 : 30), 0);
            send(r == 1 ? -30 : (r == 2 ? 10 : 30), 0);
            send(r == 1 ? -30 : (r == 2 ? 10 : 30), 0);
        end
        repeat (4) tick();
        check("s2_count", q_out.size(), 16);
        k = 0; other_clips = 0;
        for (int i = 0; i < q_out.size(); i++) begin
            if (q_ch[i] == 2) begin
                if (k < 4) begin
                    check("s2_ch2_val", q_out[i], exp2_v[k]);
                    check("s2_ch2_clip", q_clip[i], exp2_c[k]);
                end
                k++;
            end else begin
                other_clips += q_clip[i];
            end
        end
        check("s2_ch2_count", k, 4);
        check("s2_other_clips", other_clips, 0);

        // Scenario 3: sparse strobes, ignored out-of-range write, then re-frame.
        clear_log();
        lim_we = 1'b1; lim_addr = 4'd5; lim_data = 6'd1;
        tick();
        lim_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(50, 0); tick(); tick();
        end
        send(50, 1);
        repeat (4) tick();
        check("s3_count", q_out.size(), 7);
        for (int i = 0; i < 7 && i < q_out.size(); i++) begin
            check("s3_ch", q_ch[i], exp3_ch[i]);
            check("s3_val", q_out[i], exp3_v[i]);
        end

        // Scenario 4: counter saturation on ch1, then clear racing an increment.
        lim_we = 1'b1; lim_addr = 4'd1; lim_data = 6'd10;
        tick();
        lim_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(0, 1); send(50, 0);
        end
        repeat (4) tick();
        cnt_addr = 4'd1;
        tick(); tick();
        check("s4_sat", int'(clip_cnt), CNT_ON * 15);
        send(0, 1); send(50, 0);
        tick();
        check("s4_clip_now", int'(strobe_out & clip_out), 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        repeat (3) tick();
        check("s4_clear_wins", int'(clip_cnt), 0);

        // Scenario 5: reset with samples in flight.
        send(0, 1); send(50, 0); send(0, 1); send(50, 0);
        repeat (4) tick();
        check("s5_pre_cnt", int'(clip_cnt), CNT_ON * 2);
        send(10, 1);
        strobe_in = 1'b1; din = WI'(20); rst = 1'b1;
        tick();
        strobe_in = 1'b0; rst = 1'b0;
        check("s5_rst_strobe0", int'(strobe_out), 0);
        check("s5_rst_out", $signed(dout), 0);
        tick();
        check("s5_rst_strobe1", int'(strobe_out), 0);
        tick();
        check("s5_rst_strobe2", int'(strobe_out), 0);
        check("s5_rst_cnt", int'(clip_cnt), 0);
        clear_log();
        send(0, 1); send(0, 0); send(40, 0);
        repeat (4) tick();
        check("s5_count", q_out.size(), 3);
        if (q_out.size() == 3) begin
            check("s5_ch2_lim", q_out[2], 40);
            check("s5_ch2_clip", q_clip[2], 0);
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
